// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: parametrised register file with registered read ports, write bypass and busy scoreboard
module riscv_regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int RD_PORTS = 2,
  parameter bit ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [RD_PORTS*AW-1:0]   rd_addr,
  output logic [RD_PORTS*XLEN-1:0] rd_data,
  output logic [RD_PORTS-1:0]      rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NREG-1:0]          busy_vec,
  output logic [AW:0]              busy_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_nxt;
  logic [AW:0] cnt_nxt;
  logic [RD_PORTS*XLEN-1:0] rd_data_nxt;
  logic [RD_PORTS-1:0] rd_busy_nxt;
  logic wr_ok;
  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);
  // reservation wins over a same-edge write: it belongs to a newer producer
  always_comb begin
    busy_nxt = '0;
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_nxt[r] = (rsv_en && rsv_addr == AW'(r) && !(ZERO_REG && r == 0)) ? 1'b1 :
                    (wr_en && wr_addr == AW'(r)) ? 1'b0 : busy_vec[r];
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] a;
    logic z;
    assign a = rd_addr[p*AW +: AW];
    assign z = ZERO_REG && a == '0;
    assign rd_data_nxt[p*XLEN +: XLEN] = z ? '0 : (wr_ok && wr_addr == a) ? wr_data : regs[a];
    assign rd_busy_nxt[p] = !z && busy_nxt[a];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      rd_data <= '0;
      rd_busy <= '0;
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      if (rd_en) begin
        rd_data <= rd_data_nxt;
        rd_busy <= rd_busy_nxt;
      end
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: directed vector tables plus random traffic against a behavioural register-file model
module tb_riscv_regfile_sb;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic cfg = 0;
  logic rd_en = 0, wr_en = 0, rsv_en = 0;
  logic [4:0] wr_addr = 0, rsv_addr = 0;
  logic [4:0] ad [3];
  logic [63:0] wr_data = 0;

  logic [127:0] a_rd_data;
  logic [1:0]   a_rd_busy;
  logic [31:0]  a_bv;
  logic [5:0]   a_cnt;
  logic [95:0]  b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [15:0]  b_bv;
  logic [4:0]   b_cnt;

  riscv_regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en && !cfg), .rd_addr({ad[1], ad[0]}),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy), .wr_en(wr_en && !cfg), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en && !cfg), .rsv_addr(rsv_addr),
    .busy_vec(a_bv), .busy_cnt(a_cnt));

  riscv_regfile_sb #(.XLEN(32), .NREG(16), .RD_PORTS(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en && cfg), .rd_addr({ad[2][3:0], ad[1][3:0], ad[0][3:0]}),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .wr_en(wr_en && cfg), .wr_addr(wr_addr[3:0]),
    .wr_data(wr_data[31:0]), .rsv_en(rsv_en && cfg), .rsv_addr(rsv_addr[3:0]),
    .busy_vec(b_bv), .busy_cnt(b_cnt));

  // architectural view: register values, busy bits, last latched read results
  logic [63:0] mr [32];
  bit          mb [32];
  logic [63:0] md [3];
  bit          mbk [3];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic re, we; int wa; logic [63:0] wd; logic rs; int ra, a0, a1, a2;
    logic [63:0] d0, d1; logic b0; logic [31:0] bv; int cnt;
  } vec_t;
  vec_t ta[$];
  vec_t tb[$];

  function automatic vec_t v(logic re, we, int wa, logic [63:0] wd, logic rs, int ra, a0, a1, a2,
                             logic [63:0] d0, d1, logic b0, logic [31:0] bv, int cnt);
    vec_t x;
    x.re = re; x.we = we; x.wa = wa; x.wd = wd; x.rs = rs; x.ra = ra;
    x.a0 = a0; x.a1 = a1; x.a2 = a2; x.d0 = d0; x.d1 = d1; x.b0 = b0; x.bv = bv; x.cnt = cnt;
    return x;
  endfunction

  function automatic logic [63:0] get_d(int p);
    return cfg ? {32'h0, b_rd_data[p*32 +: 32]} : a_rd_data[p*64 +: 64];
  endfunction
  function automatic logic get_b(int p);
    return cfg ? b_rd_busy[p] : a_rd_busy[p];
  endfunction
  function automatic logic [31:0] get_bv();
    return cfg ? {16'h0, b_bv} : a_bv;
  endfunction
  function automatic int get_cnt();
    return cfg ? int'(b_cnt) : int'(a_cnt);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin mr[r] = '0; mb[r] = 0; end
    for (int p = 0; p < 3; p++) begin md[p] = '0; mbk[p] = 0; end
  endtask

  task automatic do_reset();
    rd_en = 0; wr_en = 0; rsv_en = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic step(logic r_e, w_e, int w_a, logic [63:0] w_d, logic r_s, int r_a, a0, a1, a2);
    int nreg, np, cnt;
    logic z;
    logic [63:0] msk;
    logic [31:0] ebv;
    nreg = cfg ? 16 : 32;
    np = cfg ? 3 : 2;
    z = !cfg;
    msk = cfg ? 64'hFFFF_FFFF : '1;
    rd_en = r_e; wr_en = w_e; wr_addr = 5'(w_a); wr_data = w_d;
    rsv_en = r_s; rsv_addr = 5'(r_a); ad[0] = 5'(a0); ad[1] = 5'(a1); ad[2] = 5'(a2);
    @(posedge clk);
    for (int r = 0; r < nreg; r++)
      if (r_s && r_a == r && !(z && r == 0)) mb[r] = 1;
      else if (w_e && w_a == r) mb[r] = 0;
    if (w_e && !(z && w_a == 0)) mr[w_a] = w_d & msk;
    if (r_e)
      for (int p = 0; p < np; p++) begin
        int a;
        a = (p == 0) ? a0 : (p == 1) ? a1 : a2;
        md[p] = mr[a];
        mbk[p] = mb[a];
      end
    @(negedge clk);
    ebv = '0;
    cnt = 0;
    for (int r = 0; r < nreg; r++) begin ebv[r] = mb[r]; cnt += int'(mb[r]); end
    for (int p = 0; p < np; p++) begin
      chk($sformatf("cfg%0d rd_data%0d", cfg, p), get_d(p), md[p]);
      chk($sformatf("cfg%0d rd_busy%0d", cfg, p), 64'(get_b(p)), 64'(mbk[p]));
    end
    chk($sformatf("cfg%0d busy_vec", cfg), 64'(get_bv()), 64'(ebv));
    chk($sformatf("cfg%0d busy_cnt", cfg), 64'(get_cnt()), 64'(cnt));
  endtask

  task automatic run_table(input vec_t t[$], string tag);
    foreach (t[i]) begin
      step(t[i].re, t[i].we, t[i].wa, t[i].wd, t[i].rs, t[i].ra, t[i].a0, t[i].a1, t[i].a2);
      chk($sformatf("%s%0d d0", tag, i), get_d(0), t[i].d0);
      chk($sformatf("%s%0d d1", tag, i), get_d(1), t[i].d1);
      chk($sformatf("%s%0d b0", tag, i), 64'(get_b(0)), 64'(t[i].b0));
      chk($sformatf("%s%0d busy_vec", tag, i), 64'(get_bv()), 64'(t[i].bv));
      chk($sformatf("%s%0d busy_cnt", tag, i), 64'(get_cnt()), 64'(t[i].cnt));
    end
  endtask

  task automatic run_random(int n);
    int nreg, hi;
    nreg = cfg ? 16 : 32;
    for (int k = 0; k < n; k++) begin
      hi = (k % 4 == 0) ? nreg - 1 : 7;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, hi),
           {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), $urandom_range(0, hi),
           $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
    end
  endtask

  initial begin
    for (int p = 0; p < 3; p++) ad[p] = 0;
    //      re we wa wd            rs ra a0 a1 a2  d0            d1    b0 bv        cnt
    ta.push_back(v(0, 1, 10, 1023,         0, 0, 0, 0, 0,  0,            0,    0, 32'h0,  0));
    ta.push_back(v(0, 1, 11, 1024,         0, 0, 0, 0, 0,  0,            0,    0, 32'h0,  0));
    ta.push_back(v(1, 0, 0, 0,             0, 0, 10, 11, 0, 1023,        1024, 0, 32'h0,  0));
    ta.push_back(v(0, 1, 10, 5,            0, 0, 0, 0, 0,  1023,         1024, 0, 32'h0,  0));
    ta.push_back(v(1, 1, 10, 64'hDEADBEEF, 0, 0, 10, 11, 0, 64'hDEADBEEF, 1024, 0, 32'h0,  0));
    ta.push_back(v(0, 1, 10, 7,            0, 0, 0, 0, 0,  64'hDEADBEEF, 1024, 0, 32'h0,  0));
    ta.push_back(v(0, 1, 0, 64'hFFFF,      1, 0, 0, 0, 0,  64'hDEADBEEF, 1024, 0, 32'h0,  0));
    ta.push_back(v(1, 0, 0, 0,             0, 0, 0, 0, 0,  0,            0,    0, 32'h0,  0));
    ta.push_back(v(0, 0, 0, 0,             1, 5, 0, 0, 0,  0,            0,    0, 32'h20, 1));
    ta.push_back(v(1, 0, 0, 0,             0, 0, 5, 10, 0, 0,            7,    1, 32'h20, 1));
    ta.push_back(v(1, 1, 5, 9,             1, 5, 5, 5, 0,  9,            9,    1, 32'h20, 1));
    ta.push_back(v(1, 1, 5, 10,            0, 0, 5, 10, 0, 10,           7,    0, 32'h0,  0));
    tb.push_back(v(0, 1, 10, 1023,         0, 0, 0, 0, 0,  0,            0,    0, 32'h0,  0));
    tb.push_back(v(0, 1, 11, 1024,         0, 0, 0, 0, 0,  0,            0,    0, 32'h0,  0));
    tb.push_back(v(1, 0, 0, 0,             0, 0, 10, 11, 0, 1023,        1024, 0, 32'h0,  0));
    tb.push_back(v(0, 1, 0, 64'h55,        0, 0, 0, 0, 0,  1023,         1024, 0, 32'h0,  0));
    tb.push_back(v(0, 0, 0, 0,             1, 0, 0, 0, 0,  1023,         1024, 0, 32'h1,  1));
    tb.push_back(v(1, 0, 0, 0,             0, 0, 0, 10, 0, 64'h55,       1023, 1, 32'h1,  1));
    tb.push_back(v(0, 0, 0, 0,             1, 5, 0, 0, 0,  64'h55,       1023, 1, 32'h21, 2));
    tb.push_back(v(1, 1, 5, 9,             1, 5, 5, 0, 0,  9,            64'h55, 1, 32'h21, 2));
    tb.push_back(v(1, 1, 5, 10,            0, 0, 5, 5, 0,  10,           10,   0, 32'h1,  1));

    do_reset();
    chk("reset a_rd_data", a_rd_data[63:0] | a_rd_data[127:64], 64'h0);
    chk("reset a_busy", 64'({a_rd_busy, a_bv, a_cnt}), 64'h0);
    chk("reset b_rd_data", b_rd_data[63:0] | {32'h0, b_rd_data[95:64]}, 64'h0);
    chk("reset b_busy", 64'({b_rd_busy, b_bv, b_cnt}), 64'h0);

    cfg = 0;
    run_table(ta, "tblA");
    run_random(300);

    // fill, reserve, read back, then yank reset between edges
    for (int i = 1; i < 32; i++) step(0, 1, i, 64'(i), 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 1, i * 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 31, 7, 0);
    #2 rst_n = 0;
    #1;
    chk("async rd_data0", get_d(0), 64'h0);
    chk("async rd_data1", get_d(1), 64'h0);
    chk("async busy_vec", 64'(get_bv()), 64'h0);
    chk("async busy_cnt", 64'(get_cnt()), 64'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0, 0, 2 * i, 2 * i + 1, 0);
      chk($sformatf("post-reset x%0d", 2 * i + 1), get_d(1), 64'h0);
    end

    cfg = 1;
    do_reset();
    run_table(tb, "tblB");
    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write integer register file used by the multicycle RISC-V datapath.
- Generalises data width, register count and read-port count.
- Adds registered A/B-style read latches with write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard, so multicycle sequencing can detect pending writes.
- Sits between the decode/issue stage and the ALU operand muxes.

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; power of 2, ≥ 2.
- AW, $clog2(NREG), address width; derived, not overridden.
- RD_PORTS, 2, number of read ports; 1 to 4.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  latch all read ports this cycle
- rd_addr  in  RD_PORTS*AW  read addresses; port p = bits [p*AW +: AW]
- rd_data  out  RD_PORTS*XLEN  registered read data; port p = bits [p*XLEN +: XLEN]
- rd_busy  out  RD_PORTS  registered busy flag of each latched read address
- wr_en  in  1  RegWrite strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- rsv_en  in  1  reserve (mark busy) destination of an issued instruction
- rsv_addr  in  AW  register to reserve
- busy_vec  out  NREG  current scoreboard bits
- busy_cnt  out  AW+1  number of set busy bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NREG registers = 0
  - rd_data = 0, rd_busy = 0
  - busy_vec = 0, busy_cnt = 0
  - Reset mid-operation discards any in-flight write or reservation in that cycle.
- Write: on a rising clk edge with wr_en=1, reg[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency is 1 cycle. On a rising clk edge with rd_en=1, each port p latches:
  - rd_data[p] <= value(rd_addr[p])
  - rd_busy[p] <= busy(rd_addr[p])
- Read hold: when rd_en=0, rd_data and rd_busy hold their previous values. They are never combinational from rd_addr.
- Bypass: if rd_en=1, wr_en=1 and rd_addr[p]==wr_addr (and it is not the zero register), then rd_data[p] latches wr_data, not the stale array value. Each port applies this independently.
- Zero register: with ZERO_REG=1, a read of address 0 always latches 0 and rd_busy = 0.
- Scoreboard (per register r, evaluated at each clock edge):
  - set if rsv_en=1 and rsv_addr==r
  - else clear if wr_en=1 and wr_addr==r
  - else hold
  - A simultaneous reserve and write to the same r leaves busy set, because the reservation is for a newer producer. The write still updates the data.
  - rsv_en to register 0 is ignored when ZERO_REG=1.
  - Re-reserving an already-busy register keeps it busy; there is no nesting count.
  - A write to a non-busy register is legal and leaves busy clear.
- Busy bypass: rd_busy[p] uses the post-update scoreboard value for that edge.
  - Same-cycle reserve of rd_addr[p] → rd_busy[p]=1.
  - Same-cycle write without reserve → rd_busy[p]=0.
- busy_cnt: registered popcount of the next busy_vec, updated on the same edge. Range 0 to NREG (NREG-1 when ZERO_REG=1); wrap-around is impossible.
- Multiple read ports may use the same address; each receives identical data.
- Out-of-range addresses cannot occur (AW is exact).

Test Plan:
- Basic write/read: reset, then write x10=1023 and x11=1024 on consecutive edges; next cycle rd_en=1, rd_addr={11,10} → one cycle later port0=1023, port1=1024, rd_busy=0.
- Bypass and hold:
  - Hold x10=5, then in one cycle wr_en=1, wr_addr=10, wr_data=0xDEAD_BEEF and rd_en=1, rd_addr[0]=10 → rd_data[0]=0xDEADBEEF, not 5.
  - Then drop rd_en, write x10=7 → rd_data[0] stays 0xDEADBEEF.
- Zero register: write x0=0xFFFF and rsv_en to x0; read x0 → rd_data=0, rd_busy=0, busy_vec[0]=0, busy_cnt=0.
- Scoreboard sequence:
  - Reserve x5 → busy_vec=0x20, busy_cnt=1.
  - Read x5 → rd_busy=1.
  - Same edge: reserve x5 and write x5=9 → busy still set, reg=9.
  - Write x5 again → busy clear, busy_cnt=0.
- Asynchronous reset mid-operation: after filling x1..x31 with their indices and reserving 8 registers, assert rst_n low between clock edges → rd_data, busy_vec and busy_cnt go to 0 immediately; a read after release returns 0 for every register.
- Parameter sweep: repeat the first and fourth scenarios with XLEN=32, NREG=16, RD_PORTS=3, ZERO_REG=0 → register 0 is writable, reads back its written value and can be reserved.
